// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer/occupancy types for the 16x32 synchronous FIFO.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int PTR_W          = $clog2(DEF_DEPTH);
  localparam int CNT_W          = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and a registered read port.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO top: pointers, occupancy counter, request gating and flag decode.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] counter;
  logic          wr, rd;

  // Gating uses the current flags, so a write against full is dropped even with a concurrent read.
  assign wr      = we_i & ~full_o;
  assign rd      = re_i & ~empty_o;
  assign full_o  = (counter == CW'(DEPTH));
  assign empty_o = (counter == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      counter <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   counter <= counter + CW'(1);
        2'b01:   counter <= counter - CW'(1);
        default: counter <= counter;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wptr),
    .wdata (data_i),
    .re    (rd),
    .raddr (rptr),
    .rdata (data_o)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: expected words queued on accepted writes, compared on reads.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_i = 1'b0, re_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        full_o, empty_o;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] m_dout;
  int          m_cnt, m_wp, m_rp;

  sync_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_i),
    .re_i    (re_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data_o"},  data_o, m_dout);
    check({tag, ".full"},    32'(full_o), 32'(m_cnt == 16));
    check({tag, ".empty"},   32'(empty_o), 32'(m_cnt == 0));
    check({tag, ".counter"}, 32'(dut.counter), 32'(m_cnt));
    check({tag, ".wptr"},    32'(dut.wptr), 32'(m_wp));
    check({tag, ".rptr"},    32'(dut.rptr), 32'(m_rp));
  endtask

  // One clock with the given requests; the model decides acceptance from its own occupancy.
  task automatic step(input string tag, input logic w, input logic r, input logic [31:0] d);
    logic mw, mr;
    we_i = w; re_i = r; data_i = d;
    mw = w && (m_cnt < 16);
    mr = r && (m_cnt > 0);
    if (mr) m_dout = sb.pop_front();
    if (mw) sb.push_back(d);
    m_cnt = m_cnt + int'(mw) - int'(mr);
    if (mw) m_wp = (m_wp + 1) % 16;
    if (mr) m_rp = (m_rp + 1) % 16;
    @(posedge clk); #1;
    we_i = 1'b0; re_i = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; we_i = 1'b1; re_i = 1'b1; data_i = 32'hFFFF_FFFF;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; we_i = 1'b0; re_i = 1'b0;
    sb.delete();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_dout = '0;
    check_state("reset");
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 32'(i));
    step("overflow", 1'b1, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, '0);
    step("underflow", 1'b0, 1'b1, '0);

    for (int i = 0; i < 16; i++) step("fill2", 1'b1, 1'b0, 32'h100 + 32'(i));
    step("full_wr_rd", 1'b1, 1'b1, 32'hBAD0_BAD0);
    for (int i = 0; i < 15; i++) step("drain2", 1'b0, 1'b1, '0);
    step("empty_wr_rd", 1'b1, 1'b1, 32'h55AA_55AA);
    step("empty_wr_rd_next", 1'b0, 1'b1, '0);
    check("empty_wr_rd_word", data_o, 32'h55AA_55AA);

    do_reset(1);
    for (int i = 0; i < 10; i++) step("wrap_w1", 1'b1, 1'b0, 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 10; i++) step("wrap_r1", 1'b0, 1'b1, '0);
    for (int i = 0; i < 12; i++) step("wrap_w2", 1'b1, 1'b0, 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 12; i++) step("wrap_r2", 1'b0, 1'b1, '0);
    check("wrap_wptr", 32'(dut.wptr), 32'd6);
    check("wrap_rptr", 32'(dut.rptr), 32'd6);
    for (int i = 0; i < 6; i++) step("stream", 1'b1, 1'b1, 32'hC000_0000 + 32'(i));

    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 32'h7700_0000 + 32'(i));
    do_reset(1);
    step("post_rst_w", 1'b1, 1'b0, 32'h1234_5678);
    step("post_rst_r", 1'b0, 1'b1, '0);
    check("post_rst_word", data_o, 32'h1234_5678);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
